// File: rtl/capture_controller.sv
// capture_controller: sequences whole-packet capture from an Avalon-ST stream
// into a [pkt_begin, pkt_end) DDR window via an Avalon-MM write master.
module capture_controller #(
  parameter int N     = 32,
  parameter int BYTES = N / 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] control,
  input  logic [N-1:0] pkt_begin,
  input  logic [N-1:0] pkt_end,
  output logic [1:0]   state,
  input  logic         st_valid,
  input  logic [N-1:0] st_data,
  input  logic         st_sop,
  input  logic         st_eop,
  output logic         st_ready,
  output logic [N-1:0] avm_address,
  output logic         avm_write,
  output logic [N-1:0] avm_writedata,
  input  logic         avm_waitrequest,
  output logic [N-1:0] wr_ptr,
  output logic [N-1:0] pkt_count,
  output logic         overflow
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    WAIT_SOP = 2'b01,
    CAPTURE  = 2'b10,
    FULL     = 2'b11
  } state_e;

  localparam logic [N-1:0] STEP       = N'(BYTES);
  localparam logic [N-1:0] ALIGN_MASK = N'(BYTES - 1);
  localparam logic [N-1:0] ONE        = N'(1);

  state_e       state_q, state_d;
  logic [N-1:0] avm_address_q, avm_address_d;
  logic [N-1:0] avm_writedata_q, avm_writedata_d;
  logic         avm_write_q, avm_write_d;
  logic [N-1:0] wr_ptr_q, wr_ptr_d;
  logic [N-1:0] pkt_count_q, pkt_count_d;
  logic         overflow_q, overflow_d;

  logic         enable;
  logic         accept;
  logic         store;
  logic         bad_cfg;
  logic         at_end;
  logic [N-1:0] ptr_inc;

  // Only ENABLE matters in the control word; the rest is the register bank's business.
  logic unused_control;
  assign unused_control = ^{control[N-1:3], control[1:0]};

  assign enable   = control[2];
  assign ptr_inc  = wr_ptr_q + STEP;
  // The beat being stored fills the last word of the window.
  assign at_end   = (ptr_inc == pkt_end);
  assign bad_cfg  = (pkt_end <= pkt_begin) || (|(pkt_begin & ALIGN_MASK)) ||
                    (|(pkt_end & ALIGN_MASK));
  // A new beat may only be taken when the write slot is free or retiring this cycle.
  assign st_ready = (state_q != IDLE) && (!avm_write_q || !avm_waitrequest);
  assign accept   = st_valid && st_ready;

  // Next-state, write-master and counter logic.
  always_comb begin
    state_d         = state_q;
    avm_address_d   = avm_address_q;
    avm_writedata_d = avm_writedata_q;
    avm_write_d     = avm_write_q;
    wr_ptr_d        = wr_ptr_q;
    pkt_count_d     = pkt_count_q;
    overflow_d      = overflow_q;
    store           = 1'b0;

    // An outstanding write retires on any cycle without waitrequest, whatever the state.
    if (avm_write_q && !avm_waitrequest) avm_write_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (enable) begin
          wr_ptr_d    = pkt_begin;
          pkt_count_d = '0;
          overflow_d  = bad_cfg;
          state_d     = bad_cfg ? FULL : WAIT_SOP;
        end
      end
      WAIT_SOP: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (accept && st_sop) begin
          store = 1'b1;
          if (st_eop) pkt_count_d = pkt_count_q + ONE;
          if (at_end) begin
            if (!st_eop) overflow_d = 1'b1;
            state_d = FULL;
          end else if (!st_eop) begin
            state_d = CAPTURE;
          end
        end
      end
      CAPTURE: begin
        // ENABLE dropping here only decides where we go after eop.
        if (accept) begin
          store = 1'b1;
          if (st_eop) begin
            pkt_count_d = pkt_count_q + ONE;
            state_d     = at_end ? FULL : (enable ? WAIT_SOP : IDLE);
          end else if (at_end) begin
            overflow_d = 1'b1;
            state_d    = FULL;
          end
        end
      end
      FULL: begin
        if (!enable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (store) begin
      avm_address_d   = wr_ptr_q;
      avm_writedata_d = st_data;
      avm_write_d     = 1'b1;
      wr_ptr_d        = ptr_inc;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      avm_address_q   <= '0;
      avm_writedata_q <= '0;
      avm_write_q     <= 1'b0;
      wr_ptr_q        <= '0;
      pkt_count_q     <= '0;
      overflow_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      avm_address_q   <= avm_address_d;
      avm_writedata_q <= avm_writedata_d;
      avm_write_q     <= avm_write_d;
      wr_ptr_q        <= wr_ptr_d;
      pkt_count_q     <= pkt_count_d;
      overflow_q      <= overflow_d;
    end
  end

  assign state         = state_q;
  assign avm_address   = avm_address_q;
  assign avm_writedata = avm_writedata_q;
  assign avm_write     = avm_write_q;
  assign wr_ptr        = wr_ptr_q;
  assign pkt_count     = pkt_count_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_capture_controller.sv
// Directed bench for capture_controller: arm, stall, full, graceful stop,
// bad config and async reset scenarios.
module tb_capture_controller;
  logic        clk;
  logic        reset;
  logic [31:0] control, pkt_begin, pkt_end;
  logic [1:0]  state;
  logic        st_valid, st_sop, st_eop, st_ready;
  logic [31:0] st_data;
  logic [31:0] avm_address, avm_writedata;
  logic        avm_write, avm_waitrequest;
  logic [31:0] wr_ptr, pkt_count;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  logic [31:0] wa[$];
  logic [31:0] wd[$];

  capture_controller #(.N(32), .BYTES(4)) dut (
    .clk(clk), .reset(reset), .control(control), .pkt_begin(pkt_begin), .pkt_end(pkt_end),
    .state(state), .st_valid(st_valid), .st_data(st_data), .st_sop(st_sop), .st_eop(st_eop),
    .st_ready(st_ready), .avm_address(avm_address), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest), .wr_ptr(wr_ptr),
    .pkt_count(pkt_count), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every completed write transfer.
  always @(posedge clk) begin
    if (avm_write === 1'b1 && avm_waitrequest === 1'b0) begin
      wa.push_back(avm_address);
      wd.push_back(avm_writedata);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send(input logic [31:0] d, input logic s, input logic e, output int waited);
    waited = 0;
    st_valid = 1'b1; st_data = d; st_sop = s; st_eop = e;
    @(negedge clk);
    while (st_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (waited >= 20) begin
      errors++;
      $display("FAIL send_timeout: beat %h st_ready=%b expected 1", d, st_ready);
    end
    @(posedge clk); #1;
    st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; control = '0; pkt_begin = '0; pkt_end = '0;
    st_valid = 1'b0; st_data = '0; st_sop = 1'b0; st_eop = 1'b0; avm_waitrequest = 1'b0;
    #12;
    @(negedge clk);
    checks++;
    if ({state, st_ready, avm_write, overflow} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: state=%b st_ready=%b avm_write=%b overflow=%b expected 0",
               state, st_ready, avm_write, overflow);
    end
    checks++;
    if ({avm_address, avm_writedata, wr_ptr, pkt_count} !== 128'b0) begin
      errors++;
      $display("FAIL reset_data: addr=%h data=%h wr_ptr=%h count=%h expected 0",
               avm_address, avm_writedata, wr_ptr, pkt_count);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic;
    int w;
    logic [31:0] ea[3];
    logic [31:0] ed[3];
    ea = '{32'h1000, 32'h1004, 32'h1008};
    ed = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002};
    pkt_begin = 32'h1000; pkt_end = 32'h1100; control = 32'h4;
    tick;
    checks++;
    if (state !== 2'b01) begin errors++; $display("FAIL arm_state: got %b expected 01", state); end
    checks++;
    if (wr_ptr !== 32'h1000) begin errors++; $display("FAIL arm_ptr: got %h expected 1000", wr_ptr); end
    wa.delete(); wd.delete();
    send(ed[0], 1'b1, 1'b0, w);
    send(ed[1], 1'b0, 1'b0, w);
    send(ed[2], 1'b0, 1'b1, w);
    tick; tick;
    checks++;
    if (wa.size() !== 3) begin errors++; $display("FAIL basic_nwrites: got %0d expected 3", wa.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= wa.size() || wa[i] !== ea[i] || wd[i] !== ed[i]) begin
        errors++;
        $display("FAIL basic_write%0d: got %h/%h expected %h/%h", i,
                 (i < wa.size()) ? wa[i] : 32'hx, (i < wd.size()) ? wd[i] : 32'hx, ea[i], ed[i]);
      end
    end
    checks++;
    if (pkt_count !== 32'd1) begin errors++; $display("FAIL basic_count: got %0d expected 1", pkt_count); end
    checks++;
    if (wr_ptr !== 32'h100C) begin errors++; $display("FAIL basic_ptr: got %h expected 100c", wr_ptr); end
    checks++;
    if (state !== 2'b01) begin errors++; $display("FAIL basic_state: got %b expected 01", state); end
    checks++;
    if (avm_write !== 1'b0) begin errors++; $display("FAIL basic_idle_write: got %b expected 0", avm_write); end
  endtask

  task automatic test_stall;
    int w;
    logic [31:0] ea[3];
    logic [31:0] ed[3];
    ea = '{32'h100C, 32'h1010, 32'h1014};
    ed = '{32'hB000_0000, 32'hB000_0001, 32'hB000_0002};
    wa.delete(); wd.delete();
    send(ed[0], 1'b1, 1'b0, w);
    send(ed[1], 1'b0, 1'b0, w);
    avm_waitrequest = 1'b1;
    st_valid = 1'b1; st_data = ed[2]; st_eop = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (st_ready !== 1'b0) begin
        errors++; $display("FAIL stall_ready%0d: got %b expected 0", c, st_ready);
      end
      checks++;
      if (avm_write !== 1'b1 || avm_address !== ea[1] || avm_writedata !== ed[1]) begin
        errors++;
        $display("FAIL stall_hold%0d: write=%b addr=%h data=%h expected 1/%h/%h",
                 c, avm_write, avm_address, avm_writedata, ea[1], ed[1]);
      end
      @(posedge clk);
    end
    #1;
    avm_waitrequest = 1'b0;
    send(ed[2], 1'b0, 1'b1, w);
    tick; tick;
    checks++;
    if (wa.size() !== 3) begin errors++; $display("FAIL stall_nwrites: got %0d expected 3", wa.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= wa.size() || wa[i] !== ea[i] || wd[i] !== ed[i]) begin
        errors++;
        $display("FAIL stall_write%0d: got %h/%h expected %h/%h", i,
                 (i < wa.size()) ? wa[i] : 32'hx, (i < wd.size()) ? wd[i] : 32'hx, ea[i], ed[i]);
      end
    end
    checks++;
    if (pkt_count !== 32'd2) begin errors++; $display("FAIL stall_count: got %0d expected 2", pkt_count); end
    checks++;
    if (wr_ptr !== 32'h1018) begin errors++; $display("FAIL stall_ptr: got %h expected 1018", wr_ptr); end
  endtask

  task automatic test_full;
    int w;
    control = '0;
    tick;
    checks++;
    if (state !== 2'b00) begin errors++; $display("FAIL disarm_state: got %b expected 00", state); end
    pkt_begin = 32'h1000; pkt_end = 32'h1008; control = 32'h4;
    tick;
    wa.delete(); wd.delete();
    send(32'hC000_0000, 1'b1, 1'b0, w);
    send(32'hC000_0001, 1'b0, 1'b0, w);
    send(32'hC000_0002, 1'b0, 1'b0, w);
    checks++;
    if (w !== 0) begin errors++; $display("FAIL full_stall2: waited %0d expected 0", w); end
    send(32'hC000_0003, 1'b0, 1'b1, w);
    checks++;
    if (w !== 0) begin errors++; $display("FAIL full_stall3: waited %0d expected 0", w); end
    tick; tick;
    checks++;
    if (wa.size() !== 2) begin errors++; $display("FAIL full_nwrites: got %0d expected 2", wa.size()); end
    checks++;
    if (wa.size() < 2 || wa[0] !== 32'h1000 || wa[1] !== 32'h1004 ||
        wd[0] !== 32'hC000_0000 || wd[1] !== 32'hC000_0001) begin
      errors++; $display("FAIL full_writes: wrong addresses/data, expected 1000/1004 c0000000/c0000001");
    end
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL full_overflow: got %b expected 1", overflow); end
    checks++;
    if (state !== 2'b11) begin errors++; $display("FAIL full_state: got %b expected 11", state); end
    checks++;
    if (pkt_count !== 32'd0) begin errors++; $display("FAIL full_count: got %0d expected 0", pkt_count); end
    checks++;
    if (wr_ptr !== 32'h1008) begin errors++; $display("FAIL full_ptr: got %h expected 1008", wr_ptr); end
  endtask

  task automatic test_graceful_stop;
    int w;
    control = '0;
    tick;
    pkt_end = 32'h1100; control = 32'h4;
    tick;
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL rearm_overflow: got %b expected 0", overflow); end
    wa.delete(); wd.delete();
    send(32'hDEAD_0000, 1'b0, 1'b0, w);
    send(32'hDEAD_0001, 1'b0, 1'b1, w);
    send(32'hE000_0000, 1'b1, 1'b0, w);
    control = '0;
    send(32'hE000_0001, 1'b0, 1'b0, w);
    checks++;
    if (state !== 2'b10) begin errors++; $display("FAIL stop_midpkt_state: got %b expected 10", state); end
    send(32'hE000_0002, 1'b0, 1'b1, w);
    tick; tick;
    checks++;
    if (state !== 2'b00) begin errors++; $display("FAIL stop_state: got %b expected 00", state); end
    checks++;
    if (wa.size() !== 3 || wa[0] !== 32'h1000 || wd[0] !== 32'hE000_0000 ||
        wa[2] !== 32'h1008 || wd[2] !== 32'hE000_0002) begin
      errors++; $display("FAIL stop_writes: got %0d writes expected 3 starting 1000/e0000000", wa.size());
    end
    checks++;
    if (pkt_count !== 32'd1) begin errors++; $display("FAIL stop_count: got %0d expected 1", pkt_count); end
  endtask

  task automatic test_bad_cfg;
    pkt_begin = 32'h2000; pkt_end = 32'h2000; control = 32'h4;
    tick;
    checks++;
    if (state !== 2'b11) begin errors++; $display("FAIL badcfg_state: got %b expected 11", state); end
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL badcfg_overflow: got %b expected 1", overflow); end
    wa.delete(); wd.delete();
    tick; tick;
    checks++;
    if (wa.size() !== 0 || avm_write !== 1'b0) begin
      errors++; $display("FAIL badcfg_nowrite: writes=%0d avm_write=%b expected 0", wa.size(), avm_write);
    end
    control = '0;
    tick;
    pkt_end = 32'h2100; control = 32'h4;
    tick;
    checks++;
    if (state !== 2'b01 || overflow !== 1'b0) begin
      errors++; $display("FAIL badcfg_rearm: state=%b overflow=%b expected 01/0", state, overflow);
    end
    checks++;
    if (wr_ptr !== 32'h2000) begin errors++; $display("FAIL badcfg_ptr: got %h expected 2000", wr_ptr); end
  endtask

  task automatic test_reset_stall;
    int w;
    send(32'hF000_0000, 1'b1, 1'b0, w);
    avm_waitrequest = 1'b1;
    @(negedge clk);
    checks++;
    if (avm_write !== 1'b1) begin errors++; $display("FAIL rst_pending: got %b expected 1", avm_write); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({state, st_ready, avm_write, overflow} !== 5'b0 ||
        {avm_address, avm_writedata, wr_ptr, pkt_count} !== 128'b0) begin
      errors++;
      $display("FAIL rst_async: state=%b wr=%b addr=%h data=%h ptr=%h cnt=%h expected 0",
               state, avm_write, avm_address, avm_writedata, wr_ptr, pkt_count);
    end
    @(negedge clk);
    reset = 1'b0; avm_waitrequest = 1'b0;
    tick;
    checks++;
    if (state !== 2'b01 || wr_ptr !== 32'h2000) begin
      errors++; $display("FAIL rst_rearm: state=%b ptr=%h expected 01/2000", state, wr_ptr);
    end
    wa.delete(); wd.delete();
    send(32'h6000_0000, 1'b1, 1'b1, w);
    tick; tick;
    checks++;
    if (wa.size() !== 1 || wa[0] !== 32'h2000 || wd[0] !== 32'h6000_0000) begin
      errors++; $display("FAIL rst_write: got %0d writes expected 1 at 2000", wa.size());
    end
    checks++;
    if (pkt_count !== 32'd1 || wr_ptr !== 32'h2004 || state !== 2'b01) begin
      errors++;
      $display("FAIL rst_single: cnt=%0d ptr=%h state=%b expected 1/2004/01", pkt_count, wr_ptr, state);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_stall;
    test_full;
    test_graceful_stop;
    test_bad_cfg;
    test_reset_stall;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
